// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the RAM arbiter.
//   state_t  : FSM encoding (IDLE -> ACCESS -> RESP -> IDLE)
//   REQ_CORE : requester 0 (core load/store path)
//   REQ_DMA  : requester 1 (debug/DMA loader)
package ram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_DMA  = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester handshakes, responses and RAM port of the arbiter.
//   slave  modport : arbiter view (requests / mem_read_data in; ready, responses,
//                    RAM strobes and BUSY out)
//   master modport : environment view (requesters + RAM), the mirror image
interface ram_arbiter_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
);
   // requester 0
   logic              REQ0_VALID;
   logic              REQ0_READY;
   logic              REQ0_WRITE;
   logic [ADDR_W-1:0] req0_address;
   logic [DATA_W-1:0] req0_write_data;
   logic              RSP0_VALID;
   logic              RSP0_ERR;
   logic [DATA_W-1:0] rsp0_read_data;
   // requester 1
   logic              REQ1_VALID;
   logic              REQ1_READY;
   logic              REQ1_WRITE;
   logic [ADDR_W-1:0] req1_address;
   logic [DATA_W-1:0] req1_write_data;
   logic              RSP1_VALID;
   logic              RSP1_ERR;
   logic [DATA_W-1:0] rsp1_read_data;
   // RAM port
   logic              MEM_READ;
   logic              MEM_WRITE;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;
   logic              BUSY;

   modport slave (
      input  REQ0_VALID, REQ0_WRITE, req0_address, req0_write_data,
      output REQ0_READY, RSP0_VALID, RSP0_ERR, rsp0_read_data,
      input  REQ1_VALID, REQ1_WRITE, req1_address, req1_write_data,
      output REQ1_READY, RSP1_VALID, RSP1_ERR, rsp1_read_data,
      output MEM_READ, MEM_WRITE, mem_address, mem_write_data, BUSY,
      input  mem_read_data
   );

   modport master (
      output REQ0_VALID, REQ0_WRITE, req0_address, req0_write_data,
      input  REQ0_READY, RSP0_VALID, RSP0_ERR, rsp0_read_data,
      output REQ1_VALID, REQ1_WRITE, req1_address, req1_write_data,
      input  REQ1_READY, RSP1_VALID, RSP1_ERR, rsp1_read_data,
      input  MEM_READ, MEM_WRITE, mem_address, mem_write_data, BUSY,
      output mem_read_data
   );
endinterface

// File: rtl/ram_arb_grant.sv
// ram_arb_grant: combinational two-requester grant.
//   req_valid[1:0] : request valids ({req1, req0})
//   ptr            : preferred requester on a tie (round-robin build only)
//   grant[1:0]     : one-hot winner, zero when nobody requests
// Build option RAM_ARB_RR_EN: defined = round-robin tie break on ptr,
// undefined = fixed priority with requester 0 winning ties.
module ram_arb_grant (
   input  logic [1:0] req_valid,
   input  logic       ptr,
   output logic [1:0] grant
);
`ifdef RAM_ARB_RR_EN
   always_comb begin
      grant = req_valid;
      if (req_valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
   end
`else
   // pointer has no meaning in fixed priority
   logic unused_ptr;
   assign unused_ptr = ptr;

   always_comb begin
      grant = 2'b00;
      if (req_valid[0])      grant = 2'b01;
      else if (req_valid[1]) grant = 2'b10;
   end
`endif
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port data RAM between requester 0 (core) and
// requester 1 (debug/DMA). One transaction at a time:
//   handshake (IDLE, cycle N) -> RAM strobe (ACCESS, N+1) -> response (RESP, N+2)
// Ports:
//   CLK   : clock, rising edge
//   RESET : synchronous, active high
//   bus   : ram_arbiter_if.slave (request/response handshakes, RAM port, BUSY)
// Build option RAM_ARB_RR_EN: round-robin tie break (adds a 1-bit pointer);
// otherwise fixed priority, requester 0 first.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64,
   parameter int DEPTH  = 128
) (
   input  logic          CLK,
   input  logic          RESET,
   ram_arbiter_if.slave  bus
);

   state_t            state, state_nx;
   logic [1:0]        req_valid, grant, ready;
   logic              ptr, hs, win_id;
   logic              lat_id, lat_wr;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata, rsp_data;
   logic              rsp_err, in_range, rsp_fire;

   assign req_valid = {bus.REQ1_VALID, bus.REQ0_VALID};
   assign win_id    = grant[1];

   ram_arb_grant u_grant (
      .req_valid (req_valid),
      .ptr       (ptr),
      .grant     (grant)
   );

`ifdef RAM_ARB_RR_EN
   // after every handshake the other requester becomes preferred
   always_ff @(posedge CLK) begin
      if (RESET)   ptr <= REQ_CORE;
      else if (hs) ptr <= ~win_id;
   end
`else
   assign ptr = REQ_CORE;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge CLK) begin
      if (RESET) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ready    = 2'b00;
      hs       = 1'b0;
      case (state)
         ST_IDLE: begin
            // grant is only non-zero under a VALID, so any grant is a handshake
            ready = grant;
            if (|grant) begin
               hs       = 1'b1;
               state_nx = ST_ACCESS;
            end
         end
         ST_ACCESS: state_nx = ST_RESP;
         ST_RESP:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   // full-width compare: high address bits never alias back into the RAM
   assign in_range = (lat_addr < ADDR_W'(DEPTH));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         lat_id    <= REQ_CORE;
         lat_wr    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (hs) begin
            lat_id    <= win_id;
            lat_wr    <= win_id ? bus.REQ1_WRITE      : bus.REQ0_WRITE;
            lat_addr  <= win_id ? bus.req1_address    : bus.req0_address;
            lat_wdata <= win_id ? bus.req1_write_data : bus.req0_write_data;
         end
         if (state == ST_ACCESS) begin
            rsp_err  <= ~in_range;
            rsp_data <= (in_range && !lat_wr) ? bus.mem_read_data : '0;
         end
      end
   end

   assign bus.REQ0_READY     = ready[0];
   assign bus.REQ1_READY     = ready[1];

   assign bus.MEM_READ       = (state == ST_ACCESS) && in_range && !lat_wr;
   assign bus.MEM_WRITE      = (state == ST_ACCESS) && in_range &&  lat_wr;
   assign bus.mem_address    = lat_addr;
   assign bus.mem_write_data = lat_wdata;

   // response always goes to the latched winner, whatever it does with VALID
   assign rsp_fire           = (state == ST_RESP);
   assign bus.RSP0_VALID     = rsp_fire && (lat_id == REQ_CORE);
   assign bus.RSP1_VALID     = rsp_fire && (lat_id == REQ_DMA);
   assign bus.RSP0_ERR       = bus.RSP0_VALID && rsp_err;
   assign bus.RSP1_ERR       = bus.RSP1_VALID && rsp_err;
   assign bus.rsp0_read_data = bus.RSP0_VALID ? rsp_data : '0;
   assign bus.rsp1_read_data = bus.RSP1_VALID ? rsp_data : '0;

   assign bus.BUSY           = (state != ST_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural 128-word RAM.
module tb_ram_arbiter;
   localparam int DW = 64, AW = 64, DEPTH = 128;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   ram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   // RAM model, with a back-door preload port
   logic [DW-1:0] ram [DEPTH];
   logic          pl_we = 1'b0;
   logic [6:0]    pl_addr = '0;
   logic [DW-1:0] pl_data = '0;
   always @(posedge CLK) begin
      if (pl_we) ram[pl_addr] <= pl_data;
      else if (bus.MEM_WRITE && bus.mem_address < AW'(DEPTH))
         ram[bus.mem_address[6:0]] <= bus.mem_write_data;
   end
   assign bus.mem_read_data = (bus.mem_address < AW'(DEPTH)) ? ram[bus.mem_address[6:0]] : '0;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // event logs, sampled on the falling edge
   typedef struct {int id; int cyc; logic [63:0] data; logic err;} ev_t;
   ev_t gnt_q[$], rd_q[$], wr_q[$], rsp_q[$];
   always @(negedge CLK) begin
      if (bus.REQ0_READY) gnt_q.push_back('{id:0, cyc:cyc, data:'0, err:1'b0});
      if (bus.REQ1_READY) gnt_q.push_back('{id:1, cyc:cyc, data:'0, err:1'b0});
      if (bus.MEM_READ)   rd_q.push_back('{id:0, cyc:cyc, data:bus.mem_address, err:1'b0});
      if (bus.MEM_WRITE)  wr_q.push_back('{id:0, cyc:cyc, data:bus.mem_address, err:1'b0});
      if (bus.RSP0_VALID) rsp_q.push_back('{id:0, cyc:cyc, data:bus.rsp0_read_data, err:bus.RSP0_ERR});
      if (bus.RSP1_VALID) rsp_q.push_back('{id:1, cyc:cyc, data:bus.rsp1_read_data, err:bus.RSP1_ERR});
   end

   int errors = 0, checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      gnt_q.delete(); rd_q.delete(); wr_q.delete(); rsp_q.delete();
   endtask

   task automatic preload(input logic [6:0] a, input logic [63:0] d);
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      @(posedge CLK); #1;
      pl_we = 1'b0;
   endtask

   task automatic set_req(input int id, input logic v, input logic wr,
                          input logic [63:0] a, input logic [63:0] d);
      if (id == 0) begin
         bus.REQ0_VALID = v; bus.REQ0_WRITE = wr; bus.req0_address = a; bus.req0_write_data = d;
      end else begin
         bus.REQ1_VALID = v; bus.REQ1_WRITE = wr; bus.req1_address = a; bus.req1_write_data = d;
      end
   endtask

   // one transaction: hold VALID until READY, drop it, let the response drain
   task automatic run_one(input int id, input logic wr, input logic [63:0] a,
                          input logic [63:0] d, output int hs);
      hs = -1;
      set_req(id, 1'b1, wr, a, d);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if ((id == 0 && bus.REQ0_READY) || (id == 1 && bus.REQ1_READY)) begin
            hs = cyc;
            break;
         end
      end
      if (hs < 0) chk("handshake_timeout", 64'd0, 64'd1);
      @(posedge CLK); #1;
      set_req(id, 1'b0, 1'b0, '0, '0);
      repeat (3) @(posedge CLK);
      #1;
   endtask

   task automatic check_rsp(input string t, input int id, input int hs,
                            input logic [63:0] d, input logic e);
      chk({t, "_rsp_count"}, rsp_q.size(), 1);
      if (rsp_q.size() > 0) begin
         chk({t, "_rsp_id"},   rsp_q[0].id,  id);
         chk({t, "_rsp_cyc"},  rsp_q[0].cyc, hs + 2);
         chk({t, "_rsp_data"}, rsp_q[0].data, d);
         chk({t, "_rsp_err"},  rsp_q[0].err,  e);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int hs;
   int order[8];
   int exp_order[8];
   int k, n0, n1;
   int bp_cyc[2];
   int bp_n;

   initial begin
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      repeat (2) @(posedge CLK);
      #1;
      // ---- reset state ----
      chk("rst_ready0",  bus.REQ0_READY, 0);
      chk("rst_ready1",  bus.REQ1_READY, 0);
      chk("rst_busy",    bus.BUSY, 0);
      chk("rst_mem_rd",  bus.MEM_READ, 0);
      chk("rst_mem_wr",  bus.MEM_WRITE, 0);
      chk("rst_mem_adr", bus.mem_address, 0);
      chk("rst_mem_wd",  bus.mem_write_data, 0);
      chk("rst_rsp0",    bus.RSP0_VALID, 0);
      chk("rst_rsp1",    bus.RSP1_VALID, 0);
      chk("rst_rdata0",  bus.rsp0_read_data, 0);
      preload(7'd10,  64'd1540);
      preload(7'd20,  64'h2020);
      preload(7'd127, 64'h127ABC);
      RESET = 1'b0;
      @(posedge CLK); #1;

      // ---- read, requester 0 ----
      clear_logs();
      run_one(0, 1'b0, 64'd10, '0, hs);
      chk("t1_gnt_count", gnt_q.size(), 1);
      chk("t1_rd_count",  rd_q.size(), 1);
      if (rd_q.size() > 0) begin
         chk("t1_rd_cyc",  rd_q[0].cyc, hs + 1);
         chk("t1_rd_addr", rd_q[0].data, 64'd10);
      end
      chk("t1_wr_count", wr_q.size(), 0);
      check_rsp("t1", 0, hs, 64'd1540, 1'b0);

      // ---- write then read, requester 1 ----
      clear_logs();
      run_one(1, 1'b1, 64'd5, 64'hDEAD, hs);
      chk("t2w_wr_count", wr_q.size(), 1);
      if (wr_q.size() > 0) begin
         chk("t2w_wr_cyc",  wr_q[0].cyc, hs + 1);
         chk("t2w_wr_addr", wr_q[0].data, 64'd5);
      end
      chk("t2w_rd_count", rd_q.size(), 0);
      chk("t2w_ram5", ram[5], 64'hDEAD);
      check_rsp("t2w", 1, hs, 64'd0, 1'b0);
      clear_logs();
      run_one(1, 1'b0, 64'd5, '0, hs);
      check_rsp("t2r", 1, hs, 64'hDEAD, 1'b0);

      // ---- range boundaries ----
      clear_logs();
      run_one(0, 1'b0, 64'd127, '0, hs);
      check_rsp("b127", 0, hs, 64'h127ABC, 1'b0);
      clear_logs();
      run_one(0, 1'b0, 64'd128, '0, hs);
      chk("b128_strobes", rd_q.size() + wr_q.size(), 0);
      check_rsp("b128", 0, hs, 64'd0, 1'b1);
      clear_logs();
      run_one(1, 1'b1, 64'h1000_0000_0000_000A, 64'h55, hs);
      chk("bhi_strobes", rd_q.size() + wr_q.size(), 0);
      chk("bhi_ram10", ram[10], 64'd1540);
      check_rsp("bhi", 1, hs, 64'd0, 1'b1);

      // ---- reset during ACCESS ----
      clear_logs();
      set_req(0, 1'b1, 1'b0, 64'd20, '0);
      hs = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (bus.REQ0_READY) begin hs = cyc; break; end
      end
      if (hs < 0) chk("rst_mid_timeout", 64'd0, 64'd1);
      @(posedge CLK); #1;
      set_req(0, 1'b0, 1'b0, '0, '0);
      RESET = 1'b1;
      chk("rst_mid_busy_access", bus.BUSY, 1);
      @(posedge CLK); #1;
      RESET = 1'b0;
      chk("rst_mid_busy_after", bus.BUSY, 0);
      repeat (4) @(posedge CLK);
      #1;
      chk("rst_mid_no_rsp", rsp_q.size(), 0);
      clear_logs();
      run_one(0, 1'b0, 64'd20, '0, hs);
      check_rsp("rst_mid_next", 0, hs, 64'h2020, 1'b0);

      // ---- backpressure: VALID held across two transactions ----
      clear_logs();
      set_req(0, 1'b1, 1'b0, 64'd10, '0);
      bp_n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (bus.REQ0_READY) begin bp_cyc[bp_n] = cyc; bp_n++; end
         if (bp_n == 2) break;
      end
      @(posedge CLK); #1;
      set_req(0, 1'b0, 1'b0, '0, '0);
      repeat (4) @(posedge CLK);
      #1;
      chk("bp_accepts", bp_n, 2);
      if (bp_n == 2) chk("bp_spacing", bp_cyc[1] - bp_cyc[0], 3);
      chk("bp_gnt_count", gnt_q.size(), 2);
      chk("bp_rsp_count", rsp_q.size(), 2);

      // ---- tie: both requesters, 4 transactions each (fresh reset) ----
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      clear_logs();
`ifdef RAM_ARB_RR_EN
      exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
      k = 0; n0 = 0; n1 = 0;
      set_req(0, 1'b1, 1'b0, 64'd10, '0);
      set_req(1, 1'b1, 1'b0, 64'd20, '0);
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (bus.REQ0_READY && bus.REQ1_READY) chk("tie_one_ready", 64'd2, 64'd1);
         if (bus.REQ0_READY && k < 8) begin order[k] = 0; k++; n0++; end
         if (bus.REQ1_READY && k < 8) begin order[k] = 1; k++; n1++; end
         @(posedge CLK); #1;
         bus.REQ0_VALID = (n0 < 4);
         bus.REQ1_VALID = (n1 < 4);
         if (k == 8) break;
      end
      repeat (4) @(posedge CLK);
      #1;
      chk("tie_grants", k, 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("tie_order%0d", i), order[i], exp_order[i]);
         if (i < rsp_q.size())
            chk($sformatf("tie_rsp%0d", i), rsp_q[i].data, exp_order[i] == 0 ? 64'd1540 : 64'h2020);
      end
      chk("tie_rsp_count", rsp_q.size(), 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters: requester 0 (core load/store path) and requester 1 (debug/DMA loader).
- Accepts one request at a time over a valid/ready handshake and sequences exactly one RAM strobe for it.
- Returns a registered response to the winning requester.
- Sits between the requesters and the RAM's MEM_READ / MEM_WRITE / address / write_data / read_data port.

Parameters:
- DATA_W, 64, data width of write and read words.
- ADDR_W, 64, width of request and RAM address buses.
- DEPTH, 128, number of RAM words; an address is in range when it is < DEPTH (word address).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ0_VALID  input  1  requester 0 has a request.
- REQ0_READY  output  1  arbiter accepts requester 0's request this cycle.
- REQ0_WRITE  input  1  1 = write, 0 = read.
- req0_address  input  ADDR_W  word address.
- req0_write_data  input  DATA_W  store data.
- RSP0_VALID  output  1  one-cycle response pulse.
- RSP0_ERR  output  1  address was out of range (qualified by RSP0_VALID).
- rsp0_read_data  output  DATA_W  read result; 0 for writes and errors.
- REQ1_* / req1_* / RSP1_* / rsp1_*  same set as requester 0, for requester 1.
- MEM_READ  output  1  RAM read strobe.
- MEM_WRITE  output  1  RAM write strobe.
- mem_address  output  ADDR_W  RAM address.
- mem_write_data  output  DATA_W  RAM write data.
- mem_read_data  input  DATA_W  RAM read data (combinational from RAM).
- BUSY  output  1  high when the state is not IDLE.

Behaviour:
- Clock and reset: one clock, CLK; RESET is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - All READY, RSP*_VALID, RSP*_ERR, MEM_READ, MEM_WRITE and BUSY outputs are 0.
  - rsp*_read_data, mem_address and mem_write_data are 0.
  - Round-robin pointer is 0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - The grant is combinational from the VALIDs.
  - REQx_READY = 1 for the winner only, in the same cycle.
  - The handshake fires on VALID & READY; op, address and data are latched along with the winner ID, and the next state is ACCESS.
  - With no VALID, the FSM stays in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_address and mem_write_data are driven from the latch.
  - In range: MEM_READ = 1 for a read or MEM_WRITE = 1 for a write, never both.
  - mem_read_data is captured into the response register at the end of the cycle.
  - Out of range (address >= DEPTH): no strobe is asserted and the error flag is set.
  - Next state is RESP.
- RESP (exactly 1 cycle):
  - RSPx_VALID = 1 for the latched winner only, with RSPx_ERR and rspx_read_data.
  - rspx_read_data is 0 for writes and for errors.
  - The requester has no backpressure on responses.
  - Next state is IDLE.
- Latency and throughput:
  - Handshake cycle N -> strobe in cycle N+1 -> RSP_VALID in cycle N+2.
  - Maximum throughput is one transaction per 3 cycles.
- READY is 0 in ACCESS and RESP. Requesters hold VALID and payload until READY.
- Simultaneous VALIDs: arbitration policy (see Optional Feature); exactly one READY.
- The response always goes to the latched winner, even if that requester has dropped VALID.
- Address bits at and above log2(DEPTH) count toward the range check; there is no wrap-around.
- RESET mid-operation: the next edge returns to IDLE and drops the pending transaction with no response. A write whose ACCESS cycle has already occurred stays committed.

Optional Feature:
- Macro: RAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer names the preferred requester.
  - After each handshake the pointer moves to the other requester than the winner.
  - On a tie the preferred requester wins.
- Undefined: fixed priority; requester 0 always wins ties and no pointer flop exists.

Decomposition:
- Shared package ram_arb_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2;
  - requester ID constants REQ_CORE = 1'b0, REQ_DMA = 1'b1.
- One sub-module, ram_arb_grant: pure-combinational grant logic (VALIDs + pointer -> one-hot grant), containing the RAM_ARB_RR_EN-dependent logic.

Test Plan:
- Read, requester 0 only: req0 read addr 10 with RAM[10] = 1540 -> MEM_READ high for 1 cycle, 2 cycles after handshake RSP0_VALID = 1, rsp0_read_data = 1540, RSP0_ERR = 0; RSP1_VALID stays 0.
- Write then read, requester 1: write 0xDEAD to addr 5, then read addr 5 -> MEM_WRITE pulse with mem_address = 5; read returns 0xDEAD.
- Tie: both VALID in the same cycle, for 4 transactions each.
  - Fixed priority: all 4 requester-0 transactions complete before any requester-1 transaction.
  - RAM_ARB_RR_EN: grants alternate 0, 1, 0, 1.
- Out of range: read addr 128 -> no MEM_READ or MEM_WRITE pulse, RSP0_ERR = 1, rsp0_read_data = 0.
- Reset mid-op: assert RESET during ACCESS of a read -> next cycle state IDLE, BUSY = 0, no RSP pulse; the next request completes normally.
- Backpressure: VALID held through ACCESS/RESP -> READY = 0 in those cycles; a second accept occurs 3 cycles after the first.
